// File: rtl/arbitro_rr.sv
// Round-robin arbiter/router from N_IN source FIFOs to N_OUT destination FIFOs.
// Optional per-destination push counters are compiled in when ARB_CNT_EN is defined.
//
// state  | meaning
// INIT   | first cycle out of reset, no grant allowed
// IDLE   | every source empty
// ACTIVE | a word was granted this cycle
// STALL  | work pending but every candidate destination is almost full
module arbitro_rr #(
    parameter int DATA_W = 12,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN-1:0]          empty,
    input  logic [N_IN*DATA_W-1:0]   data_in,
    input  logic [N_OUT-1:0]         almost_full,
    output logic [N_IN-1:0]          pop,
    output logic [N_OUT-1:0]         push,
    output logic [DATA_W-1:0]        data_out,
    output logic [1:0]               state
`ifdef ARB_CNT_EN
    ,
    output logic [N_OUT*8-1:0]       cnt
`endif
);

    localparam int DEST_W = $clog2(N_OUT);
    localparam int IDX_W  = $clog2(N_IN);
    localparam logic [IDX_W:0] N_IN_W = (IDX_W+1)'(N_IN);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [N_IN-1:0]    elig;
    logic [DEST_W-1:0]  dest [N_IN];
    logic               gnt_any, gnt_fire;
    logic [IDX_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  gnt_word;
    logic [DEST_W-1:0]  gnt_dest;
    logic [N_OUT-1:0]   push_nxt;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W:0]   off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + off;
        if (s >= N_IN_W)
            s = s - N_IN_W;
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            dest[i] = data_in[i*DATA_W + DATA_W - DEST_W +: DEST_W];
            elig[i] = ~empty[i] & ~almost_full[dest[i]];
        end
    end

    // Scan downward so the last hit, i.e. the closest to rr_ptr, wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = wrap_add(rr_ptr, (IDX_W+1)'(k));
            if (elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign gnt_fire = gnt_any & ~reset & (state_q != ST_INIT);
    assign gnt_word = data_in[gnt_idx*DATA_W +: DATA_W];
    assign gnt_dest = gnt_word[DATA_W-1 -: DEST_W];

    always_comb begin
        push_nxt           = '0;
        push_nxt[gnt_dest] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_INIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_INIT)
            state_d = ST_IDLE;
        else if (gnt_fire)
            state_d = ST_ACTIVE;
        else if (|(~empty))
            state_d = ST_STALL;
        else
            state_d = ST_IDLE;
    end

    always_comb begin
        pop = '0;
        if (gnt_fire)
            pop[gnt_idx] = 1'b1;
    end

    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push     <= '0;
            data_out <= '0;
            rr_ptr   <= '0;
        end else if (gnt_fire) begin
            push     <= push_nxt;
            data_out <= gnt_word;
            rr_ptr   <= wrap_add(gnt_idx, (IDX_W+1)'(1));
        end else begin
            push     <= '0;
        end
    end

`ifdef ARB_CNT_EN
    logic [7:0] cnt_q [N_OUT];

    for (genvar d = 0; d < N_OUT; d++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt_q[d] <= '0;
            else if (push[d] && (cnt_q[d] != 8'hFF))
                cnt_q[d] <= cnt_q[d] + 8'd1;
        end
        assign cnt[d*8 +: 8] = cnt_q[d];
    end
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: expected pushes go into a scoreboard queue,
// a negedge monitor pops and compares them against push/data_out.
module tb_arbitro_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  empty;
    logic [11:0] head [4];
    logic [47:0] data_in;
    logic [3:0]  almost_full;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [11:0] data_out;
    logic [1:0]  state;
`ifdef ARB_CNT_EN
    logic [31:0] cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0]  push;
        logic [11:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq [$];

    assign data_in = {head[3], head[2], head[1], head[0]};

    arbitro_rr dut (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty),
        .data_in     (data_in),
        .almost_full (almost_full),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .state       (state)
`ifdef ARB_CNT_EN
        ,
        .cnt         (cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed push must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && push != 4'b0000) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_push: got push=%b data=%h, expected none (cycle %0d)",
                         push, data_out, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (push !== e.push || data_out !== e.data || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL push_word: got push=%b data=%h cyc=%0d, expected push=%b data=%h cyc=%0d",
                             push, data_out, cyc, e.push, e.data, e.cyc);
                end
            end
        end
    end

    // Check pop/state mid-cycle, queue the push this pop must produce, advance a cycle.
    task automatic step(input logic [3:0] exp_pop, input logic [1:0] exp_state);
        exp_t e;
        logic [11:0] w;
        @(negedge clk);
        check("pop", 32'(pop), 32'(exp_pop));
        check("state", 32'(state), 32'(exp_state));
        if (exp_pop != 4'b0000) begin
            w = 12'h000;
            for (int i = 0; i < 4; i++)
                if (exp_pop[i]) w = head[i];
            e.push = 4'b0001 << w[11:10];
            e.data = w;
            e.cyc  = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_heads(input logic [11:0] h0, input logic [11:0] h1,
                             input logic [11:0] h2, input logic [11:0] h3);
        head[0] = h0;
        head[1] = h1;
        head[2] = h2;
        head[3] = h3;
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] route_words [4];
        route_words[0] = 12'h012;
        route_words[1] = 12'h456;
        route_words[2] = 12'h8D1;
        route_words[3] = 12'hCD9;

        reset       = 1'b1;
        empty       = 4'b0000;
        almost_full = 4'b0000;
        set_heads(12'h456, 12'h456, 12'h456, 12'h456);

        // reset held with all sources non-empty
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_push", 32'(push), 32'h0);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_state", 32'(state), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b0000, 2'd0);

        // fairness: all heads route to destination 1
        step(4'b0001, 2'd1);
        step(4'b0010, 2'd2);
        step(4'b0100, 2'd2);
        step(4'b1000, 2'd2);
        step(4'b0001, 2'd2);

        // routing: source 0 alone
        empty = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            head[0] = route_words[i];
            step(4'b0001, 2'd2);
        end
        empty = 4'b1111;
        step(4'b0000, 2'd2);
        step(4'b0000, 2'd1);

        // backpressure: destinations 1..3 almost full, only dest-0 heads move
        almost_full = 4'b1110;
        empty       = 4'b0000;
        set_heads(12'h8D1, 12'h012, 12'hCD9, 12'h012);
        step(4'b0010, 2'd1);
        step(4'b1000, 2'd2);
        step(4'b0010, 2'd2);
        step(4'b1000, 2'd2);
        almost_full = 4'b1111;
        step(4'b0000, 2'd2);
        step(4'b0000, 2'd3);
        step(4'b0000, 2'd3);
        almost_full = 4'b0000;
        step(4'b0001, 2'd3);
        step(4'b0010, 2'd2);

        // mid-traffic reset; the word popped just before it is dropped
        set_heads(12'h456, 12'h456, 12'h456, 12'h456);
        step(4'b0100, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_pop", 32'(pop), 32'h0);
        check("mid_push", 32'(push), 32'h0);
        check("mid_data", 32'(data_out), 32'h0);
        check("mid_state", 32'(state), 32'h0);
        check("mid_sb_pending", 32'(sbq.size()), 32'd1);
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b0000, 2'd0);
        step(4'b0001, 2'd1);
        empty = 4'b1111;
        step(4'b0000, 2'd2);
        step(4'b0000, 2'd1);

`ifdef ARB_CNT_EN
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        empty = 4'b1110;
        head[0] = 12'hCD9;
        step(4'b0000, 2'd0);
        for (int i = 0; i < 300; i++)
            step(4'b0001, (i == 0) ? 2'd1 : 2'd2);
        empty = 4'b1111;
        step(4'b0000, 2'd2);
        step(4'b0000, 2'd1);
        @(negedge clk);
        check("cnt3_sat", 32'(cnt[31:24]), 32'd255);
        check("cnt_others", 32'(cnt[23:0]), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arbitro_rr.md
# arbitro_rr

Parametrised round-robin arbiter/router between N_IN source FIFOs and N_OUT destination FIFOs. Each cycle it grants one non-empty source whose head word's destination FIFO is not almost full, pops that word and pushes it one cycle later into the FIFO selected by the word's top bits. It sits between the input FIFO bank and the output FIFO bank. It is the generalised successor of the fixed single-input, 4-output, 12-bit arbiter, with multi-source fairness, stall tracking and optional traffic counters.

## Interface
- DATA_W, 12, word width in bits.
- N_IN, 4, number of source FIFOs, 2..8.
- N_OUT, 4, number of destination FIFOs, a power of two from 2 to 8. DEST_W = log2(N_OUT).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- empty  in  N_IN  empty flag per source FIFO; bit i belongs to source i.
- data_in  in  N_IN*DATA_W  first-word-fall-through head words; source i occupies [i*DATA_W +: DATA_W].
- almost_full  in  N_OUT  per destination; must assert while at least 1 free slot remains.
- pop  out  N_IN  one-hot or zero; combinational read strobe to the sources.
- push  out  N_OUT  one-hot or zero; registered write strobe to the destinations.
- data_out  out  DATA_W  registered word accompanying push.
- state  out  2  FSM state: INIT=0, IDLE=1, ACTIVE=2, STALL=3.
- cnt  out  N_OUT*8  per-destination push counters; present only with ARB_CNT_EN.

## Operation
- Destination of a source's head word is data_in word bits [DATA_W-1 : DATA_W-DEST_W].
- Source i is eligible when empty[i]=0 and almost_full[dest(i)]=0.
- Grant: search starts at rr_ptr and moves upward modulo N_IN. The first eligible source wins. A blocked source is skipped, so there is no head-of-line blocking across sources.
- pop[g]=1 for the granted source g in the same cycle. No pop is issued while reset=1 or state=INIT.
- On the edge that ends a grant cycle:
  - push <= onehot(dest(g)), data_out <= head word of g.
  - rr_ptr <= (g+1) mod N_IN.
- With no grant: push <= 0; data_out holds its value; rr_ptr holds.
- FSM next-state logic:
  - INIT -> IDLE unconditionally.
  - From any other state: ACTIVE if a grant occurs this cycle; else STALL if any empty[i]=0; else IDLE.
- Several sources targeting the same destination are served one per cycle in rotation.
- All-empty input: stay in IDLE, pop=0.
- All sources non-empty but every destination almost full: STALL, pop=0, rr_ptr frozen.
- Reset mid-operation: pop is forced low at once and push/data_out clear asynchronously. A word popped on the edge coincident with reset assertion is dropped by design.

## Timing
- Reset values: pop=0, push=0, data_out=0, state=INIT, rr_ptr=0, cnt=0.
- First pop possible in the 2nd cycle after reset deasserts (after one INIT cycle).
- Latency: pop in cycle n gives push/data_out valid in cycle n+1, high for exactly one cycle per word.
- Throughput: 1 word/cycle sustained.
- almost_full is sampled in the pop cycle. One word may land one cycle after almost_full rises, which is why the flag needs its 1-slot margin.
- The empty/data_in head is assumed to update on the edge following pop. The arbiter never pops a source whose empty=1.

## Configuration
- ARB_CNT_EN defined:
  - cnt is present, with one 8-bit counter per destination.
  - A counter increments on each cycle its push bit is 1.
  - Counters saturate at 255 and clear on reset.
- ARB_CNT_EN undefined:
  - Port cnt and all counter logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset behaviour: hold reset=1 for 3 cycles with empty=4'b0000 -> pop=0, push=0, data_out=0x000, state=0. One cycle after release state=0 (INIT) with pop=0. The next cycle state=1 and pop is active.
- Routing: source 0 alone presents 0x012, 0x456, 0x8D1, 0xCD9 on consecutive cycles -> push = 0001, 0010, 0100, 1000 with data_out = 0x012, 0x456, 0x8D1, 0xCD9, each 1 cycle after its pop.
- Fairness: all 4 sources non-empty, all heads 0x456 -> pop rotates 0001, 0010, 0100, 1000, 0001. push=0010 every cycle.
- Backpressure and skip: almost_full=4'b1110; sources 0..3 hold heads 0x8D1, 0x012, 0xCD9, 0x012 -> only sources 1 and 3 are popped, alternately. Then almost_full=4'b1111 -> pop=0 and state=3. On release, rr_ptr resumes where it stopped.
- Mid-traffic reset: assert reset asynchronously mid-cycle during a burst -> push/pop drop within the same cycle, state=0, rr_ptr=0.
- Counters (ARB_CNT_EN): push 300 words of 0xCD9 -> cnt[31:24]=255 (saturated), other counters 0.
